// File: rtl/sm_pkg.sv
// Shared SM-level constants and fetch-path types.
package sm_pkg;

    localparam int NUM_WARP = 8;
    localparam int WID_W    = 3;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT
    } fetch_state_e;

    typedef struct packed {
        logic [WID_W-1:0]  wid;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_inst_t;

endpackage

// File: rtl/sm_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sm_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // N is a power of two, so the IDX_W-bit add wraps at N.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/sm_fetch_arbiter.sv
// Shares the program-memory read port among the warps of one SM: round-robin issue,
// one outstanding read, and a holding register toward decode with per-warp flush.
module sm_fetch_arbiter
    import sm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WARP-1:0]        fetch_req_i,
    input  logic [NUM_WARP*ADDR_W-1:0] fetch_pc_i,
    output logic [NUM_WARP-1:0]        fetch_grant_o,
    input  logic                       flush_i,
    input  logic [WID_W-1:0]           flush_wid_i,
    input  logic                       program_mem_available_i,
    output logic                       program_read_valid_o,
    output logic [ADDR_W-1:0]          program_read_addr_o,
    output logic [WID_W-1:0]           program_read_wid_o,
    input  logic                       program_read_ready_i,
    input  logic [DATA_W-1:0]          program_read_data_i,
    output logic                       inst_valid_o,
    output logic [DATA_W-1:0]          inst_o,
    output logic [WID_W-1:0]           inst_wid_o,
    output logic [ADDR_W-1:0]          inst_pc_o,
    input  logic                       inst_ready_i
);

    fetch_state_e        state_q, state_d;
    logic [WID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                drop_q, drop_d;
    logic [NUM_WARP-1:0] grant_q, grant_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [WID_W-1:0]    rd_wid_q, rd_wid_d;
    logic                inst_valid_q, inst_valid_d;
    fetch_inst_t         inst_q, inst_d;

    logic [NUM_WARP-1:0] flush_mask;
    logic [NUM_WARP-1:0] eligible;
    logic [NUM_WARP-1:0] pick_grant;
    logic [WID_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [ADDR_W-1:0]   pc_arr [NUM_WARP];
    logic                flush_rd_hit;
    logic                flush_out_hit;

    always_comb begin
        flush_mask              = '0;
        flush_mask[flush_wid_i] = flush_i;
        for (int i = 0; i < NUM_WARP; i++) begin
            pc_arr[i] = fetch_pc_i[i*ADDR_W +: ADDR_W];
        end
    end

    assign eligible      = fetch_req_i & ~flush_mask;
    assign flush_rd_hit  = flush_i && (flush_wid_i == rd_wid_q);
    assign flush_out_hit = flush_i && (flush_wid_i == inst_q.wid);

    sm_rr_arbiter #(
        .N     (NUM_WARP),
        .IDX_W (WID_W)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        drop_d       = drop_q;
        grant_d      = '0;
        rd_valid_d   = rd_valid_q;
        rd_addr_d    = rd_addr_q;
        rd_wid_d     = rd_wid_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        unique case (state_q)
            IDLE: begin
                if (program_mem_available_i && pick_valid) begin
                    state_d    = WAIT;
                    rd_valid_d = 1'b1;
                    rd_addr_d  = pc_arr[pick_idx];
                    rd_wid_d   = pick_idx;
                    grant_d    = pick_grant;
                    rr_ptr_d   = pick_idx + WID_W'(1);
                end
            end
            WAIT: begin
                if (flush_rd_hit) begin
                    drop_d = 1'b1;
                end
                if (program_read_ready_i) begin
                    rd_valid_d = 1'b0;
                    rd_addr_d  = '0;
                    rd_wid_d   = '0;
                    // A flush landing on the response cycle still discards it.
                    if (drop_q || flush_rd_hit) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d      = OUT;
                        inst_valid_d = 1'b1;
                        inst_d.wid   = rd_wid_q;
                        inst_d.pc    = rd_addr_q;
                        inst_d.inst  = program_read_data_i;
                    end
                end
            end
            OUT: begin
                if (flush_out_hit || inst_ready_i) begin
                    state_d      = IDLE;
                    inst_valid_d = 1'b0;
                    inst_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            drop_q       <= 1'b0;
            grant_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_wid_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_q       <= drop_d;
            grant_q      <= grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_addr_q    <= rd_addr_d;
            rd_wid_q     <= rd_wid_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
        end
    end

    assign fetch_grant_o        = grant_q;
    assign program_read_valid_o = rd_valid_q;
    assign program_read_addr_o  = rd_addr_q;
    assign program_read_wid_o   = rd_wid_q;
    assign inst_valid_o         = inst_valid_q;
    assign inst_o               = inst_q.inst;
    assign inst_wid_o           = inst_q.wid;
    assign inst_pc_o            = inst_q.pc;

endmodule

// File: tb/tb_sm_fetch_arbiter.sv
// Bench for sm_fetch_arbiter: transaction-level reference checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sm_fetch_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   fetch_req_i;
    logic [255:0] fetch_pc_i;
    logic [7:0]   fetch_grant_o;
    logic         flush_i;
    logic [2:0]   flush_wid_i;
    logic         program_mem_available_i;
    logic         program_read_valid_o;
    logic [31:0]  program_read_addr_o;
    logic [2:0]   program_read_wid_o;
    logic         program_read_ready_i;
    logic [31:0]  program_read_data_i;
    logic         inst_valid_o;
    logic [31:0]  inst_o;
    logic [2:0]   inst_wid_o;
    logic [31:0]  inst_pc_o;
    logic         inst_ready_i;

    sm_fetch_arbiter dut (
        .clk                     (clk),
        .rst                     (rst),
        .fetch_req_i             (fetch_req_i),
        .fetch_pc_i              (fetch_pc_i),
        .fetch_grant_o           (fetch_grant_o),
        .flush_i                 (flush_i),
        .flush_wid_i             (flush_wid_i),
        .program_mem_available_i (program_mem_available_i),
        .program_read_valid_o    (program_read_valid_o),
        .program_read_addr_o     (program_read_addr_o),
        .program_read_wid_o      (program_read_wid_o),
        .program_read_ready_i    (program_read_ready_i),
        .program_read_data_i     (program_read_data_i),
        .inst_valid_o            (inst_valid_o),
        .inst_o                  (inst_o),
        .inst_wid_o              (inst_wid_o),
        .inst_pc_o               (inst_pc_o),
        .inst_ready_i            (inst_ready_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    // Memory responder: one ready pulse mem_lat cycles after a read becomes visible.
    bit mem_auto = 1'b1;
    int mem_lat  = 1;
    int mem_cnt  = 0;
    bit mem_done = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mem_auto) begin
            program_read_ready_i = 1'b0;
            if (!program_read_valid_o) begin
                mem_cnt  = 0;
                mem_done = 1'b0;
            end else if (!mem_done) begin
                if (mem_cnt == mem_lat) begin
                    program_read_ready_i = 1'b1;
                    program_read_data_i  = mem_word(program_read_addr_o);
                    mem_done             = 1'b1;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Reference: at most one read in flight (m_rd) or one instruction held (m_hold).
    int          m_rd   = -1;
    int          m_hold = -1;
    int          m_ptr  = 0;
    int          m_start;
    int          m_w;
    bit          m_drop = 1'b0;
    logic [31:0] m_rd_addr, m_hold_pc, m_hold_data;
    logic [7:0]  m_grant = '0;

    always @(posedge clk) begin
        m_grant = '0;
        if (rst) begin
            m_rd   = -1;
            m_hold = -1;
            m_ptr  = 0;
            m_drop = 1'b0;
        end else if (m_hold >= 0) begin
            if ((flush_i && int'(flush_wid_i) == m_hold) || inst_ready_i) m_hold = -1;
        end else if (m_rd >= 0) begin
            if (flush_i && int'(flush_wid_i) == m_rd) m_drop = 1'b1;
            if (program_read_ready_i) begin
                if (!m_drop) begin
                    m_hold      = m_rd;
                    m_hold_pc   = m_rd_addr;
                    m_hold_data = program_read_data_i;
                end
                m_rd   = -1;
                m_drop = 1'b0;
            end
        end else if (program_mem_available_i) begin
            m_start = m_ptr;
            for (int k = 0; k < 8; k++) begin
                m_w = (m_start + k) % 8;
                if (m_grant == 0 && fetch_req_i[m_w] && !(flush_i && int'(flush_wid_i) == m_w)) begin
                    m_grant[m_w] = 1'b1;
                    m_rd         = m_w;
                    m_rd_addr    = fetch_pc_i[m_w*32 +: 32];
                    m_ptr        = (m_w + 1) % 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", fetch_grant_o, m_grant);
            chk("rd_valid", program_read_valid_o, m_rd >= 0);
            chk("rd_addr", program_read_addr_o, (m_rd >= 0) ? m_rd_addr : 32'h0);
            chk("rd_wid", program_read_wid_o, (m_rd >= 0) ? 3'(m_rd) : 3'h0);
            chk("inst_valid", inst_valid_o, m_hold >= 0);
            chk("inst", inst_o, (m_hold >= 0) ? m_hold_data : 32'h0);
            chk("inst_wid", inst_wid_o, (m_hold >= 0) ? 3'(m_hold) : 3'h0);
            chk("inst_pc", inst_pc_o, (m_hold >= 0) ? m_hold_pc : 32'h0);
        end
    end

    int got [$];

    function automatic int oh2i(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic collect(input int cnt, input int budget);
        int n = 0;
        got.delete();
        while (got.size() < cnt && n < budget) begin
            cyc(1);
            n++;
            if (fetch_grant_o != 0) got.push_back(oh2i(fetch_grant_o));
        end
        chk("grant_count", got.size(), cnt);
    endtask

    task automatic wait_inst(input int budget);
        int n = 0;
        while (!inst_valid_o && n < budget) begin
            cyc(1);
            n++;
        end
        chk("wait_inst", inst_valid_o, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((program_read_valid_o || inst_valid_o) && n < budget) begin
            cyc(1);
            n++;
        end
        chk("wait_idle", program_read_valid_o | inst_valid_o, 1'b0);
    endtask

    task automatic set_pc(input int w, input logic [31:0] v);
        fetch_pc_i[w*32 +: 32] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int rr_exp [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        rst = 1'b1;
        fetch_req_i = '0;
        fetch_pc_i = '0;
        flush_i = 1'b0;
        flush_wid_i = '0;
        program_mem_available_i = 1'b1;
        program_read_ready_i = 1'b0;
        program_read_data_i = '0;
        inst_ready_i = 1'b1;
        for (int w = 0; w < 8; w++) set_pc(w, 32'h1000 + 32'(w) * 32'h100);
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("rst_grant", fetch_grant_o, 8'h00);
        chk("rst_rd_valid", program_read_valid_o, 1'b0);
        chk("rst_inst_valid", inst_valid_o, 1'b0);

        // Single fetch of warp 2.
        set_pc(2, 32'h40);
        fetch_req_i = 8'b0000_0100;
        cyc(1);
        fetch_req_i = '0;
        chk("single_grant", fetch_grant_o, 8'h04);
        chk("single_addr", program_read_addr_o, 32'h40);
        chk("single_wid", program_read_wid_o, 3'd2);
        wait_inst(10);
        chk("single_inst", inst_o, 32'hDEAD_0040);
        chk("single_iwid", inst_wid_o, 3'd2);
        chk("single_ipc", inst_pc_o, 32'h40);
        cyc(1);
        chk("single_handoff", inst_valid_o, 1'b0);
        wait_idle(10);

        // Round-robin from a fresh pointer with every warp requesting.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        mem_lat = 0;
        fetch_req_i = 8'hFF;
        collect(9, 60);
        fetch_req_i = '0;
        for (int i = 0; i < 9; i++) chk("rr_order", (i < got.size()) ? got[i] : -1, rr_exp[i]);
        wait_idle(10);
        fetch_req_i = 8'b1000_0001;
        collect(2, 30);
        fetch_req_i = '0;
        chk("rr_wrap_first", (got.size() > 0) ? got[0] : -1, 7);
        chk("rr_wrap_second", (got.size() > 1) ? got[1] : -1, 0);
        wait_idle(10);

        // Downstream backpressure with another warp waiting.
        mem_lat = 1;
        inst_ready_i = 1'b0;
        set_pc(5, 32'h500);
        fetch_req_i = 8'b0010_0000;
        wait_inst(10);
        fetch_req_i = 8'b0000_0001;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", inst_valid_o, 1'b1);
            chk("bp_inst", inst_o, 32'hDEAD_0500);
            chk("bp_no_read", program_read_valid_o, 1'b0);
            cyc(1);
        end
        inst_ready_i = 1'b1;
        cyc(1);
        chk("bp_released", inst_valid_o, 1'b0);
        cyc(1);
        fetch_req_i = '0;
        chk("bp_next_grant", fetch_grant_o, 8'h01);
        wait_idle(10);

        // Memory unavailable, then a slow response.
        program_mem_available_i = 1'b0;
        fetch_req_i = 8'b0001_0000;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("stall_grant", fetch_grant_o, 8'h00);
            chk("stall_rd_valid", program_read_valid_o, 1'b0);
        end
        mem_lat = 4;
        program_mem_available_i = 1'b1;
        cyc(1);
        fetch_req_i = '0;
        chk("stall_issue", fetch_grant_o, 8'h10);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("slow_rd_valid", program_read_valid_o, 1'b1);
            chk("slow_rd_addr", program_read_addr_o, 32'h1400);
        end
        wait_inst(10);
        chk("slow_inst", inst_o, 32'hDEAD_1400);
        wait_idle(10);

        // Flush warp 3 while its read is outstanding.
        mem_auto = 1'b0;
        set_pc(3, 32'h300);
        fetch_req_i = 8'b0000_1000;
        cyc(1);
        fetch_req_i = '0;
        chk("fw_grant", fetch_grant_o, 8'h08);
        cyc(1);
        flush_i = 1'b1;
        flush_wid_i = 3'd3;
        cyc(1);
        flush_i = 1'b0;
        cyc(1);
        program_read_ready_i = 1'b1;
        program_read_data_i = 32'h1234;
        cyc(1);
        program_read_ready_i = 1'b0;
        chk("fw_dropped", inst_valid_o, 1'b0);
        chk("fw_rd_done", program_read_valid_o, 1'b0);
        cyc(2);
        chk("fw_still_empty", inst_valid_o, 1'b0);

        // Flush coinciding with the response.
        fetch_req_i = 8'b0000_1000;
        cyc(1);
        fetch_req_i = '0;
        flush_i = 1'b1;
        program_read_ready_i = 1'b1;
        program_read_data_i = 32'h5678;
        cyc(1);
        flush_i = 1'b0;
        program_read_ready_i = 1'b0;
        chk("fr_same_cycle", inst_valid_o, 1'b0);
        chk("fr_rd_done", program_read_valid_o, 1'b0);

        // Flush warp 3 while its instruction is held, without and with inst_ready.
        mem_auto = 1'b1;
        mem_lat = 0;
        inst_ready_i = 1'b0;
        fetch_req_i = 8'b0000_1000;
        wait_inst(10);
        fetch_req_i = '0;
        flush_i = 1'b1;
        cyc(1);
        flush_i = 1'b0;
        chk("fo_dropped", inst_valid_o, 1'b0);
        fetch_req_i = 8'b0000_1000;
        wait_inst(10);
        fetch_req_i = '0;
        flush_i = 1'b1;
        inst_ready_i = 1'b1;
        cyc(1);
        flush_i = 1'b0;
        chk("fo_ready_dropped", inst_valid_o, 1'b0);
        wait_idle(10);

        // Flush of another warp does nothing.
        mem_auto = 1'b0;
        inst_ready_i = 1'b0;
        fetch_req_i = 8'b0000_1000;
        cyc(1);
        fetch_req_i = '0;
        flush_i = 1'b1;
        flush_wid_i = 3'd5;
        cyc(1);
        flush_i = 1'b0;
        program_read_ready_i = 1'b1;
        program_read_data_i = 32'h77;
        cyc(1);
        program_read_ready_i = 1'b0;
        chk("fx_valid", inst_valid_o, 1'b1);
        chk("fx_inst", inst_o, 32'h77);
        chk("fx_wid", inst_wid_o, 3'd3);
        flush_i = 1'b1;
        cyc(1);
        flush_i = 1'b0;
        chk("fx_out_kept", inst_valid_o, 1'b1);
        inst_ready_i = 1'b1;
        cyc(1);
        chk("fx_released", inst_valid_o, 1'b0);

        // Reset while waiting on memory, then a late response.
        fetch_req_i = 8'b0000_1000;
        cyc(1);
        fetch_req_i = '0;
        chk("rw_grant", fetch_grant_o, 8'h08);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rw_rd_valid", program_read_valid_o, 1'b0);
        chk("rw_rd_addr", program_read_addr_o, 32'h0);
        chk("rw_inst_valid", inst_valid_o, 1'b0);
        program_read_ready_i = 1'b1;
        program_read_data_i = 32'h99;
        cyc(1);
        program_read_ready_i = 1'b0;
        chk("rw_late_ignored", inst_valid_o, 1'b0);
        fetch_req_i = 8'hFF;
        cyc(1);
        fetch_req_i = '0;
        chk("rw_ptr_zero", fetch_grant_o, 8'h01);
        mem_auto = 1'b1;
        mem_lat = 0;
        wait_idle(20);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
